// File: rtl/mac_tx_interface.sv
// MAC transmit interface: reads committed frames from the 512x64 Tx buffer
// and streams them to the 10G MAC Tx client, publishing the freed read address.
module mac_tx_interface #(
    parameter int MAX_BYTES = 2048
) (
    input  logic        clk,
    input  logic        reset,
    output logic [8:0]  rd_addr,
    input  logic [63:0] rd_data,
    input  logic        commited_wr_address_change,
    input  logic [9:0]  commited_wr_address,
    output logic [9:0]  commited_rd_address,
    output logic [63:0] tx_data,
    output logic [7:0]  tx_data_valid,
    output logic        tx_start,
    input  logic        tx_ack,
    output logic [31:0] tx_frames_counter,
    output logic [31:0] bad_frames_counter
);

    typedef enum logic [2:0] {
        IDLE, HDR, START, WAIT_ACK, STREAM, DONE, FLUSH
    } state_t;

    state_t      state_q, state_d;
    logic        chg_q1, chg_q2;
    logic [9:0]  wr_addr_q, wr_ptr_sync_q;
    logic [8:0]  rd_addr_q, rd_addr_d;
    logic [9:0]  cra_q, cra_d;
    logic [63:0] tx_data_q, tx_data_d;
    logic [7:0]  valid_q, valid_d;
    logic        start_q, start_d;
    logic [31:0] frames_q, frames_d;
    logic [31:0] bad_q, bad_d;
    logic [8:0]  words_q, words_d;
    logic [7:0]  mask_q, mask_d;
    logic [8:0]  idx_q, idx_d;
    logic        last_q, last_d;
    logic [63:0] pf_q, pf_d;
    logic        first_q, first_d;

    logic        empty;
    logic [31:0] hdr_len;
    logic        hdr_bad;
    logic [11:0] len_round;
    logic [8:0]  hdr_words;
    logic [7:0]  hdr_mask;
    logic [9:0]  next_ptr;
    logic        unused_ok;

    assign empty     = (cra_q == wr_ptr_sync_q);
    assign hdr_len   = rd_data[63:32];
    assign hdr_bad   = (hdr_len == 32'd0) || (hdr_len > 32'(MAX_BYTES));
    assign len_round = hdr_len[11:0] + 12'd7;
    assign hdr_words = len_round[11:3];
    assign next_ptr  = cra_q + 10'd1 + {1'b0, words_q};
    assign unused_ok = ^{rd_data[31:0], len_round[2:0]};

    assign rd_addr             = rd_addr_q;
    assign commited_rd_address = cra_q;
    assign tx_data             = tx_data_q;
    assign tx_data_valid       = valid_q;
    assign tx_start            = start_q;
    assign tx_frames_counter   = frames_q;
    assign bad_frames_counter  = bad_q;

    // Valid mask for the final word: low L%8 bytes, or all 8 when aligned
    always_comb begin
        hdr_mask = 8'hFF;
        if (hdr_len[2:0] != 3'd0)
            hdr_mask = 8'hFF >> (4'd8 - {1'b0, hdr_len[2:0]});
    end

    // Bring the writer's committed address across: 2-flop level, 1-flop data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chg_q1        <= 1'b0;
            chg_q2        <= 1'b0;
            wr_addr_q     <= '0;
            wr_ptr_sync_q <= '0;
        end else begin
            chg_q1    <= commited_wr_address_change;
            chg_q2    <= chg_q1;
            wr_addr_q <= commited_wr_address;
            if (chg_q2)
                wr_ptr_sync_q <= wr_addr_q;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (!empty) state_d = HDR;
            HDR:      state_d = hdr_bad ? FLUSH : START;
            START:    state_d = WAIT_ACK;
            WAIT_ACK: if (tx_ack) state_d = last_q ? DONE : STREAM;
            STREAM:   if (last_q) state_d = DONE;
            DONE:     state_d = IDLE;
            FLUSH:    state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // FSM outputs and datapath next values; reads run two words ahead
    always_comb begin
        rd_addr_d = rd_addr_q;
        cra_d     = cra_q;
        tx_data_d = tx_data_q;
        valid_d   = valid_q;
        start_d   = start_q;
        frames_d  = frames_q;
        bad_d     = bad_q;
        words_d   = words_q;
        mask_d    = mask_q;
        idx_d     = idx_q;
        last_d    = last_q;
        pf_d      = pf_q;
        first_d   = first_q;
        unique case (state_q)
            IDLE: begin
                if (!empty) rd_addr_d = cra_q[8:0] + 9'd1;
            end
            HDR: begin
                words_d   = hdr_words;
                mask_d    = hdr_mask;
                rd_addr_d = rd_addr_q + 9'd1;
            end
            START: begin
                tx_data_d = rd_data;
                start_d   = 1'b1;
                last_d    = (words_q == 9'd1);
                valid_d   = (words_q == 9'd1) ? mask_q : 8'hFF;
                idx_d     = 9'd1;
                first_d   = 1'b1;
                rd_addr_d = rd_addr_q + 9'd1;
            end
            WAIT_ACK: begin
                first_d = 1'b0;
                if (first_q) pf_d = rd_data;
                if (tx_ack) begin
                    start_d = 1'b0;
                    if (last_q) begin
                        valid_d = 8'h00;
                    end else begin
                        tx_data_d = first_q ? rd_data : pf_q;
                        last_d    = (words_q == 9'd2);
                        valid_d   = (words_q == 9'd2) ? mask_q : 8'hFF;
                        idx_d     = 9'd2;
                        rd_addr_d = rd_addr_q + 9'd1;
                    end
                end
            end
            STREAM: begin
                if (last_q) begin
                    valid_d = 8'h00;
                end else begin
                    tx_data_d = rd_data;
                    last_d    = (idx_q == words_q - 9'd1);
                    valid_d   = (idx_q == words_q - 9'd1) ? mask_q : 8'hFF;
                    idx_d     = idx_q + 9'd1;
                    rd_addr_d = rd_addr_q + 9'd1;
                end
            end
            DONE: begin
                valid_d   = 8'h00;
                cra_d     = next_ptr;
                rd_addr_d = next_ptr[8:0];
                frames_d  = frames_q + 32'd1;
            end
            FLUSH: begin
                cra_d     = wr_ptr_sync_q;
                rd_addr_d = wr_ptr_sync_q[8:0];
                bad_d     = bad_q + 32'd1;
            end
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_addr_q <= '0;
            cra_q     <= '0;
            tx_data_q <= '0;
            valid_q   <= '0;
            start_q   <= 1'b0;
            frames_q  <= '0;
            bad_q     <= '0;
            words_q   <= '0;
            mask_q    <= '0;
            idx_q     <= '0;
            last_q    <= 1'b0;
            pf_q      <= '0;
            first_q   <= 1'b0;
        end else begin
            rd_addr_q <= rd_addr_d;
            cra_q     <= cra_d;
            tx_data_q <= tx_data_d;
            valid_q   <= valid_d;
            start_q   <= start_d;
            frames_q  <= frames_d;
            bad_q     <= bad_d;
            words_q   <= words_d;
            mask_q    <= mask_d;
            idx_q     <= idx_d;
            last_q    <= last_d;
            pf_q      <= pf_d;
            first_q   <= first_d;
        end
    end

endmodule

// File: tb/tb_mac_tx_interface.sv
// Directed bench for mac_tx_interface: buffer model, framing,
// corrupt-header flush, pointer wrap, sync gating and async reset.
module tb_mac_tx_interface;

    logic        clk;
    logic        reset;
    logic [8:0]  rd_addr;
    logic [63:0] rd_data;
    logic        commited_wr_address_change;
    logic [9:0]  commited_wr_address;
    logic [9:0]  commited_rd_address;
    logic [63:0] tx_data;
    logic [7:0]  tx_data_valid;
    logic        tx_start;
    logic        tx_ack;
    logic [31:0] tx_frames_counter;
    logic [31:0] bad_frames_counter;

    logic [63:0] mem [512];
    int n_vec;
    int n_err;

    mac_tx_interface #(.MAX_BYTES(2048)) dut (
        .clk                        (clk),
        .reset                      (reset),
        .rd_addr                    (rd_addr),
        .rd_data                    (rd_data),
        .commited_wr_address_change (commited_wr_address_change),
        .commited_wr_address        (commited_wr_address),
        .commited_rd_address        (commited_rd_address),
        .tx_data                    (tx_data),
        .tx_data_valid              (tx_data_valid),
        .tx_start                   (tx_start),
        .tx_ack                     (tx_ack),
        .tx_frames_counter          (tx_frames_counter),
        .bad_frames_counter         (bad_frames_counter)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read buffer: data one cycle after address
    always @(posedge clk) rd_data <= mem[rd_addr];

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] dat(input int x);
        logic [31:0] xv;
        xv = 32'(x);
        return {32'hC0DE_0000 | xv, 32'h5A5A_0000 | xv};
    endfunction

    task automatic put_frame(input int p, input int len, input int w);
        mem[p % 512] = {32'(len), 32'hFFFF_FFFF};
        for (int k = 1; k <= w; k++)
            mem[(p + k) % 512] = dat((p + k) % 1024);
    endtask

    task automatic commit(input int v);
        commited_wr_address_change = 1'b0;
        repeat (3) @(negedge clk);
        commited_wr_address = 10'(v);
        @(negedge clk);
        commited_wr_address_change = 1'b1;
    endtask

    task automatic wait_start(output bit ok);
        int n;
        n = 0;
        while (tx_start !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        ok = (tx_start === 1'b1);
    endtask

    // Receive one frame at header P with W words and final mask lm
    task automatic rx_frame(input int p, input int w,
                            input logic [7:0] lm, input int dly);
        bit ok;
        wait_start(ok);
        chk("start_seen", 64'(ok), 64'd1);
        for (int i = 0; i < dly; i++) begin
            chk("start_hold", 64'(tx_start), 64'd1);
            chk("w0_hold", tx_data, dat((p + 1) % 1024));
            @(negedge clk);
        end
        chk("w0_data", tx_data, dat((p + 1) % 1024));
        chk("w0_valid", 64'(tx_data_valid), 64'((w == 1) ? lm : 8'hFF));
        tx_ack = 1'b1;
        @(negedge clk);
        tx_ack = 1'b0;
        chk("start_drop", 64'(tx_start), 64'd0);
        for (int k = 1; k < w; k++) begin
            chk("wk_data", tx_data, dat((p + 1 + k) % 1024));
            chk("wk_valid", 64'(tx_data_valid),
                64'((k == w - 1) ? lm : 8'hFF));
            @(negedge clk);
        end
        chk("tail_off", 64'(tx_data_valid), 64'd0);
    endtask

    task automatic watch_quiet(input int n, output bit seen);
        seen = 1'b0;
        repeat (n) begin
            @(negedge clk);
            if (tx_start === 1'b1) seen = 1'b1;
        end
    endtask

    initial begin
        bit seen;
        bit ok;
        bit hit;
        n_vec = 0;
        n_err = 0;
        for (int i = 0; i < 512; i++) mem[i] = '0;
        reset = 1'b1;
        tx_ack = 1'b0;
        commited_wr_address_change = 1'b0;
        commited_wr_address = '0;
        repeat (3) @(negedge clk);
        chk("rst_rd_addr", 64'(rd_addr), 64'd0);
        chk("rst_start", 64'(tx_start), 64'd0);
        chk("rst_valid", 64'(tx_data_valid), 64'd0);
        chk("rst_data", tx_data, 64'd0);
        chk("rst_cra", 64'(commited_rd_address), 64'd0);
        chk("rst_frames", 64'(tx_frames_counter), 64'd0);
        chk("rst_bad", 64'(bad_frames_counter), 64'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        put_frame(0, 64, 8);
        commit(9);
        rx_frame(0, 8, 8'hFF, 3);
        repeat (3) @(negedge clk);
        chk("f1_cra", 64'(commited_rd_address), 64'd9);
        chk("f1_frames", 64'(tx_frames_counter), 64'd1);

        put_frame(9, 61, 8);
        commit(18);
        rx_frame(9, 8, 8'h1F, 0);
        repeat (3) @(negedge clk);
        chk("f2_cra", 64'(commited_rd_address), 64'd18);

        put_frame(18, 1, 1);
        commit(20);
        rx_frame(18, 1, 8'h01, 1);
        repeat (3) @(negedge clk);
        chk("f3_cra", 64'(commited_rd_address), 64'd20);
        chk("f3_frames", 64'(tx_frames_counter), 64'd3);

        put_frame(20, 0, 0);
        commit(25);
        watch_quiet(12, seen);
        chk("bad0_nostart", 64'(seen), 64'd0);
        chk("bad0_cra", 64'(commited_rd_address), 64'd25);
        chk("bad0_cnt", 64'(bad_frames_counter), 64'd1);

        put_frame(25, 4000, 0);
        commit(30);
        watch_quiet(12, seen);
        chk("bad4k_nostart", 64'(seen), 64'd0);
        chk("bad4k_cra", 64'(commited_rd_address), 64'd30);
        chk("bad4k_cnt", 64'(bad_frames_counter), 64'd2);

        put_frame(30, 5000, 0);
        commit(1016);
        repeat (12) @(negedge clk);
        chk("jump_cra", 64'(commited_rd_address), 64'd1016);
        chk("jump_bad", 64'(bad_frames_counter), 64'd3);

        put_frame(1016, 100, 13);
        put_frame(6, 16, 2);
        commit(9);
        rx_frame(1016, 13, 8'h0F, 0);
        chk("wrap_frames", 64'(tx_frames_counter), 64'd3);
        chk("wrap_gap_nostart", 64'(tx_start), 64'd0);
        @(negedge clk);
        chk("wrap_cra", 64'(commited_rd_address), 64'd6);
        rx_frame(6, 2, 8'hFF, 2);
        repeat (3) @(negedge clk);
        chk("wrap2_cra", 64'(commited_rd_address), 64'd9);
        chk("wrap2_frames", 64'(tx_frames_counter), 64'd5);

        put_frame(9, 8, 1);
        commited_wr_address_change = 1'b0;
        repeat (4) @(negedge clk);
        commited_wr_address = 10'd11;
        watch_quiet(10, seen);
        chk("sync_nostart", 64'(seen), 64'd0);
        chk("sync_noread", 64'(rd_addr), 64'd9);
        commited_wr_address_change = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 4 && !hit; i++) begin
            @(negedge clk);
            if (rd_addr == 9'd10) hit = 1'b1;
        end
        chk("sync_read_lat", 64'(hit), 64'd1);
        rx_frame(9, 1, 8'hFF, 0);
        repeat (3) @(negedge clk);
        chk("sync_cra", 64'(commited_rd_address), 64'd11);
        chk("sync_frames", 64'(tx_frames_counter), 64'd6);

        put_frame(11, 80, 10);
        commit(22);
        wait_start(ok);
        chk("rst_f_start", 64'(ok), 64'd1);
        tx_ack = 1'b1;
        @(negedge clk);
        tx_ack = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_f_w5", tx_data, dat(17));
        chk("rst_f_w5v", 64'(tx_data_valid), 64'hFF);
        #2 reset = 1'b1;
        #1;
        chk("arst_valid", 64'(tx_data_valid), 64'd0);
        chk("arst_start", 64'(tx_start), 64'd0);
        chk("arst_data", tx_data, 64'd0);
        chk("arst_rd_addr", 64'(rd_addr), 64'd0);
        chk("arst_cra", 64'(commited_rd_address), 64'd0);
        chk("arst_frames", 64'(tx_frames_counter), 64'd0);
        commited_wr_address_change = 1'b0;
        commited_wr_address = '0;
        @(negedge clk);
        reset = 1'b0;
        watch_quiet(8, seen);
        chk("post_rst_quiet", 64'(seen), 64'd0);
        chk("post_rst_cra", 64'(commited_rd_address), 64'd0);
        chk("post_rst_rd_addr", 64'(rd_addr), 64'd0);
        chk("post_rst_valid", 64'(tx_data_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
